// File: rtl/key_conditioner.sv
// key_conditioner: per-channel push-button synchronizer, debouncer, press/release
// edge pulses and optional auto-repeat.
// Optional feature: define KEY_CONDITIONER_AUTOREPEAT_EN to build the repeat FSM;
// without it key_repeat is tied low and the repeat logic is not built.

module key_conditioner_lane #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 25000,
    parameter int REPEAT_PERIOD   = 5000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_level,
    output logic o_level_nxt,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);
    // Raw level of a key that is not being pressed.
    localparam logic REL_LVL = (ACTIVE_LOW != 0);
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic [DW-1:0] r_dcnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          w_p;
    logic          w_diff;
    logic          w_accept;
    logic          w_press_nxt;
    logic          w_rel_nxt;

    // Two-flop synchronizer; reset parks it at the released level so no
    // spurious press is seen as reset drops.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_sync <= {2{REL_LVL}};
        else       r_sync <= {r_sync[0], i_key};
    end

    assign w_p         = (ACTIVE_LOW != 0) ? ~r_sync[1] : r_sync[1];
    assign w_diff      = w_p ^ r_level;
    // The cycle the counter already holds DEBOUNCE_CYCLES-1 is the last
    // differing cycle needed, so the level flips on this edge.
    assign w_accept    = w_diff && (r_dcnt >= DB_LAST);
    assign w_press_nxt = w_accept & w_p;
    assign w_rel_nxt   = w_accept & ~w_p;
    assign o_level_nxt = w_accept ? w_p : r_level;

    // Debounce counter, accepted level and registered edge pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dcnt    <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_level   <= o_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_rel_nxt;
            if (!w_diff || w_accept) r_dcnt <= '0;
            else if (r_dcnt != '1)   r_dcnt <= r_dcnt + 1'b1;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RMAX) + 1;
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [1:0] ST_RELEASED    = 2'd0;
    localparam logic [1:0] ST_HELD_DELAY  = 2'd1;
    localparam logic [1:0] ST_HELD_REPEAT = 2'd2;

    logic [1:0]    r_state;
    logic [RW-1:0] r_rcnt;
    logic          r_repeat;

    // Repeat FSM advances on the same edge the press/release pulse is
    // registered, so release always wins over a coincident repeat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_RELEASED;
            r_rcnt   <= '0;
            r_repeat <= 1'b0;
        end else begin
            r_repeat <= 1'b0;
            case (r_state)
                ST_RELEASED: begin
                    r_rcnt <= '0;
                    if (w_press_nxt) r_state <= ST_HELD_DELAY;
                end
                ST_HELD_DELAY: begin
                    if (w_rel_nxt) begin
                        r_state <= ST_RELEASED;
                        r_rcnt  <= '0;
                    end else if (r_rcnt >= RD_LAST) begin
                        r_state  <= ST_HELD_REPEAT;
                        r_rcnt   <= '0;
                        r_repeat <= 1'b1;
                    end else if (r_rcnt != '1) begin
                        r_rcnt <= r_rcnt + 1'b1;
                    end
                end
                ST_HELD_REPEAT: begin
                    if (w_rel_nxt) begin
                        r_state <= ST_RELEASED;
                        r_rcnt  <= '0;
                    end else if (r_rcnt >= RP_LAST) begin
                        r_rcnt   <= '0;
                        r_repeat <= 1'b1;
                    end else if (r_rcnt != '1) begin
                        r_rcnt <= r_rcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RELEASED;
                    r_rcnt  <= '0;
                end
            endcase
        end
    end

    assign o_repeat = r_repeat;
`else
    assign o_repeat = 1'b0;
`endif
endmodule

module key_conditioner #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 25000,
    parameter int REPEAT_PERIOD   = 5000
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic [CHANNELS-1:0] KEY,
    output logic [CHANNELS-1:0] key_level,
    output logic [CHANNELS-1:0] key_press,
    output logic [CHANNELS-1:0] key_release,
    output logic [CHANNELS-1:0] key_repeat,
    output logic                any_pressed
);
    logic [CHANNELS-1:0] w_level_nxt;
    logic                r_any;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        key_conditioner_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_lane (
            .i_clk       (CLOCK_50),
            .i_rst       (RESET),
            .i_key       (KEY[g]),
            .o_level     (key_level[g]),
            .o_level_nxt (w_level_nxt[g]),
            .o_press     (key_press[g]),
            .o_release   (key_release[g]),
            .o_repeat    (key_repeat[g])
        );
    end

    // any_pressed is built from next-level so it lands on the same edge as key_level.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) r_any <= 1'b0;
        else       r_any <= |w_level_nxt;
    end

    assign any_pressed = r_any;
endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner (CHANNELS=4, DEBOUNCE=8, REPEAT 20/5).
// Follows KEY_CONDITIONER_AUTOREPEAT_EN to decide whether repeats are expected.
module tb_key_conditioner;
    localparam int RD  = 20;
    localparam int RP  = 5;
    localparam int LAT = 10;   // sampling edge + 9 more edges
    localparam int K_PRESS = 0, K_REL = 1, K_REP = 2;

    logic       CLOCK_50 = 1'b0;
    logic       RESET    = 1'b1;
    logic [3:0] KEY      = 4'hF;
    logic [3:0] key_level, key_press, key_release, key_repeat;
    logic       any_pressed;

    key_conditioner #(
        .CHANNELS(4), .DEBOUNCE_CYCLES(8), .ACTIVE_LOW(1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .KEY(KEY),
        .key_level(key_level), .key_press(key_press), .key_release(key_release),
        .key_repeat(key_repeat), .any_pressed(any_pressed)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct { int cyc; int kind; int ch; } ev_t;
    ev_t        sbq[$];
    int         cyc    = 0;
    bit         mon_en = 1'b0;
    int         n_chk  = 0;
    int         n_pass = 0;
    logic [3:0] exp_lvl = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic void push(input int c, input int k, input int ch);
        ev_t e;
        e.cyc = c; e.kind = k; e.ch = ch;
        sbq.push_back(e);
    endfunction

    // Hold the masked keys low for n cycles, queueing every expected event.
    task automatic hold(input logic [3:0] mask, input int n);
        int c;
        @(negedge CLOCK_50);
        c = cyc;
        KEY = KEY & ~mask;
        for (int ch = 0; ch < 4; ch++) begin
            if (mask[ch]) begin
                push(c + LAT, K_PRESS, ch);
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
                for (int t = c + LAT + RD; t < c + n + LAT; t += RP) push(t, K_REP, ch);
`endif
                push(c + n + LAT, K_REL, ch);
            end
        end
        repeat (n) @(negedge CLOCK_50);
        KEY = KEY | mask;
        repeat (14) @(negedge CLOCK_50);
    endtask

    // Monitor: pop what is due this cycle and compare against the outputs.
    always @(posedge CLOCK_50) begin : mon
        logic [3:0] ep, er, et;
        cyc = cyc + 1;
        #1;
        if (mon_en) begin
            ep = '0; er = '0; et = '0;
            for (int i = sbq.size() - 1; i >= 0; i--) begin
                if (sbq[i].cyc == cyc) begin
                    case (sbq[i].kind)
                        K_PRESS: ep[sbq[i].ch] = 1'b1;
                        K_REL:   er[sbq[i].ch] = 1'b1;
                        default: et[sbq[i].ch] = 1'b1;
                    endcase
                    sbq.delete(i);
                end
            end
            if (RESET) exp_lvl = '0;
            else       exp_lvl = (exp_lvl | ep) & ~er;
            chk("press",   32'(key_press),   32'(ep));
            chk("release", 32'(key_release), 32'(er));
            chk("repeat",  32'(key_repeat),  32'(et));
            chk("level",   32'(key_level),   32'(exp_lvl));
            chk("any",     32'(any_pressed), 32'(|exp_lvl));
        end
    end

    initial begin
        int r, d;
        repeat (3) @(negedge CLOCK_50);
        chk("rst_level",   32'(key_level),   32'h0);
        chk("rst_press",   32'(key_press),   32'h0);
        chk("rst_release", 32'(key_release), 32'h0);
        chk("rst_repeat",  32'(key_repeat),  32'h0);
        chk("rst_any",     32'(any_pressed), 32'h0);
        mon_en = 1'b1;
        RESET  = 1'b0;
        repeat (3) @(negedge CLOCK_50);

        // Single clean press/release on channel 0.
        hold(4'b0001, 30);

        // Short glitches: 5 cycles and one below the debounce threshold.
        @(negedge CLOCK_50); KEY[1] = 1'b0;
        repeat (5) @(negedge CLOCK_50); KEY[1] = 1'b1;
        repeat (12) @(negedge CLOCK_50);
        chk("glitch5_lvl", 32'(key_level[1]), 32'h0);
        @(negedge CLOCK_50); KEY[3] = 1'b0;
        repeat (7) @(negedge CLOCK_50); KEY[3] = 1'b1;
        repeat (12) @(negedge CLOCK_50);
        chk("glitch7_lvl", 32'(key_level[3]), 32'h0);

        // Exactly the debounce length is accepted.
        hold(4'b1000, 8);

        // Long hold with auto-repeat on channel 2.
        hold(4'b0100, 60);

        // Simultaneous press on channels 0 and 3.
        hold(4'b1001, 25);

        // Reset mid-debounce: key re-qualifies from scratch afterwards.
        @(negedge CLOCK_50); KEY[1] = 1'b0;
        repeat (4) @(negedge CLOCK_50); RESET = 1'b1;
        repeat (2) @(negedge CLOCK_50); RESET = 1'b0;
        r = cyc;
        push(r + LAT, K_PRESS, 1);
        repeat (12) @(negedge CLOCK_50);
        d = cyc;
        KEY[1] = 1'b1;
        push(d + LAT, K_REL, 1);
        repeat (14) @(negedge CLOCK_50);

        chk("sbq_empty", 32'(sbq.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent key channels (1..16).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000, consecutive stable cycles required to accept a level change (>=1).
REQ-003 Parameter ACTIVE_LOW, default 1, 1 = KEY low means pressed, 0 = KEY high means pressed.
REQ-004 Parameter REPEAT_DELAY, default 25000, cycles from accepted press to first repeat pulse (>=1).
REQ-005 Parameter REPEAT_PERIOD, default 5000, cycles between subsequent repeat pulses (>=1).
REQ-006 CLOCK_50  in  1  sole clock, all logic on rising edge.
REQ-007 RESET  in  1  synchronous, active-high reset.
REQ-008 KEY  in  CHANNELS  raw asynchronous push-button inputs.
REQ-009 key_level  out  CHANNELS  debounced pressed state per channel, 1 = pressed.
REQ-010 key_press  out  CHANNELS  one-cycle pulse on accepted press.
REQ-011 key_release  out  CHANNELS  one-cycle pulse on accepted release.
REQ-012 key_repeat  out  CHANNELS  one-cycle auto-repeat pulse while held.
REQ-013 any_pressed  out  1  OR of key_level.

Function
REQ-014 Each KEY bit SHALL pass through a two-flop synchronizer, then be polarity-normalised per ACTIVE_LOW to a pressed bit p.
REQ-015 Per channel, a counter SHALL increment each cycle p differs from key_level and clear to 0 on any cycle p equals key_level.
REQ-016 On the DEBOUNCE_CYCLES-th consecutive differing cycle, key_level SHALL take p and the counter SHALL clear.
REQ-017 Latency: a clean KEY change SHALL appear on key_level DEBOUNCE_CYCLES+2 rising edges after (and counting) the edge that first samples it.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no output change.
REQ-019 key_press / key_release SHALL be registered, high exactly in the first cycle key_level shows the new value, never both in one cycle for a channel.
REQ-020 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-021 Per-channel repeat FSM states: RELEASED, HELD_DELAY, HELD_REPEAT.
REQ-022 RELEASED -> HELD_DELAY on key_press, repeat counter cleared.
REQ-023 HELD_DELAY -> HELD_REPEAT after REPEAT_DELAY cycles, with key_repeat pulsed in that cycle.
REQ-024 In HELD_REPEAT, key_repeat SHALL pulse every REPEAT_PERIOD cycles thereafter.
REQ-025 Any state -> RELEASED on key_release, same cycle; no key_repeat in or after that cycle.
REQ-026 key_repeat SHALL never coincide with key_press on the same channel.
REQ-027 Counter widths SHALL be $clog2 of the largest applicable parameter plus 1; counters SHALL saturate, never wrap.
REQ-028 any_pressed SHALL be registered-output derived, same cycle as key_level.

Reset
REQ-029 While RESET is high at a clock edge: synchronizers load released level, all counters 0, key_level 0, all pulse outputs 0, any_pressed 0, FSMs RELEASED.
REQ-030 RESET mid-debounce or mid-repeat SHALL discard progress; a key held through reset SHALL be re-qualified from zero after RESET falls (full REQ-017 latency, then key_press).

Configuration
REQ-031 Macro KEY_CONDITIONER_AUTOREPEAT_EN defined: REQ-021..REQ-026 implemented as stated.
REQ-032 Macro undefined: repeat FSM and counters absent, key_repeat tied to 0, all other behaviour identical.

Verification (CHANNELS=4, DEBOUNCE_CYCLES=8, ACTIVE_LOW=1, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-033 RESET high 3 cycles, KEY=4'hF -> key_level=0, all pulses 0, any_pressed=0.
REQ-034 KEY[0] 1->0 held -> key_level[0]=1 and key_press[0] one cycle at edge 10 after sampling edge, any_pressed=1.
REQ-035 KEY[1] low for 5 cycles then high -> key_level[1] stays 0, no pulses.
REQ-036 KEY[2] held low 60 cycles (macro on) -> key_repeat[2] at press+20, +25, +30, +35 ...; release -> key_release[2], no further repeats; macro off -> key_repeat always 0.
REQ-037 KEY[0] and KEY[3] fall same edge -> key_press[0] and key_press[3] same cycle.
REQ-038 KEY[1] low, RESET pulsed 2 cycles at press+4 -> no key_press until 10 edges after RESET falls.
